// File: rtl/stopwatch_timer.sv
// MM:SS elapsed-time counter with a CLK_DIV prescaler and registered tick/rollover pulses.
// Optional lap-freeze display register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_timer #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       lap,
  output logic [5:0] seconds,
  output logic [6:0] minutes,
  output logic [5:0] disp_sec,
  output logic [6:0] disp_min,
  output logic       sec_tick,
  output logic       rollover,
  output logic       lap_held
);

  localparam int unsigned PreW = $clog2(CLK_DIV);
  localparam logic [PreW-1:0] PreLast = PreW'(CLK_DIV - 1);
  localparam logic [PreW-1:0] PreOne  = PreW'(1);
  localparam logic [6:0] MinLast = 7'(MAX_MIN);

  logic [PreW-1:0] pre_q, pre_d;
  logic [5:0]      sec_q, sec_d;
  logic [6:0]      min_q, min_d;
  logic            tick_q, tick_d;
  logic            roll_q, roll_d;

  always_comb begin
    pre_d  = pre_q;
    sec_d  = sec_q;
    min_d  = min_q;
    tick_d = 1'b0;
    roll_d = 1'b0;
    if (clear) begin
      pre_d = '0;
      sec_d = '0;
      min_d = '0;
    end else if (enable) begin
      if (pre_q == PreLast) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == MinLast) begin
            min_d  = '0;
            roll_d = 1'b1;
          end else begin
            min_d = min_q + 7'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + PreOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      tick_q <= 1'b0;
      roll_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      tick_q <= tick_d;
      roll_q <= roll_d;
    end
  end

  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign sec_tick = tick_q;
  assign rollover = roll_q;

`ifdef STOPWATCH_LAP_EN
  logic       held_q, held_d;
  logic [5:0] dsec_q, dsec_d;
  logic [6:0] dmin_q, dmin_d;

  // Lap captures the live value present before this edge's count update.
  always_comb begin
    held_d = held_q;
    dsec_d = dsec_q;
    dmin_d = dmin_q;
    if (clear) begin
      held_d = 1'b0;
      dsec_d = '0;
      dmin_d = '0;
    end else if (lap) begin
      if (!held_q) begin
        held_d = 1'b1;
        dsec_d = sec_q;
        dmin_d = min_q;
      end else begin
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= 1'b0;
      dsec_q <= '0;
      dmin_q <= '0;
    end else begin
      held_q <= held_d;
      dsec_q <= dsec_d;
      dmin_q <= dmin_d;
    end
  end

  assign disp_sec = held_q ? dsec_q : sec_q;
  assign disp_min = held_q ? dmin_q : min_q;
  assign lap_held = held_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp_sec   = sec_q;
  assign disp_min   = min_q;
  assign lap_held   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer (CLK_DIV=4, MAX_MIN=99): expected ticks are queued
// by the stimulus and checked by an independent monitor whenever sec_tick is seen.
module tb_stopwatch_timer;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned MaxMin = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [5:0] seconds;
  logic [6:0] minutes;
  logic [5:0] disp_sec;
  logic [6:0] disp_min;
  logic       sec_tick;
  logic       rollover;
  logic       lap_held;

  stopwatch_timer #(
    .CLK_DIV(ClkDiv),
    .MAX_MIN(MaxMin)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clear   (clear),
    .lap     (lap),
    .seconds (seconds),
    .minutes (minutes),
    .disp_sec(disp_sec),
    .disp_min(disp_min),
    .sec_tick(sec_tick),
    .rollover(rollover),
    .lap_held(lap_held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int min;
    int roll;
    int dsec;
    int dmin;
    int held;
  } tick_t;

  tick_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_pre = 0, m_sec = 0, m_min = 0;
  int m_held = 0, m_lsec = 0, m_lmin = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_sec = 0; m_min = 0; m_held = 0; m_lsec = 0; m_lmin = 0;
  endtask

  // One clock: drive inputs, advance the model, queue an expected tick if one is due.
  task automatic step(input bit en, input bit clr, input bit lp);
    tick_t t;
    bit    tick;
    int    roll;
    enable = en; clear = clr; lap = lp;
    tick = 0; roll = 0;
    if (clr) begin
      model_reset();
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (lp) begin
        if (m_held == 0) begin
          m_held = 1; m_lsec = m_sec; m_lmin = m_min;
        end else begin
          m_held = 0;
        end
      end
`endif
      if (en) begin
        m_pre++;
        if (m_pre == ClkDiv) begin
          m_pre = 0;
          tick = 1;
          m_sec++;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min++;
            if (m_min == MaxMin + 1) begin
              m_min = 0;
              roll = 1;
            end
          end
        end
      end
    end
    if (tick) begin
      t.sec = m_sec; t.min = m_min; t.roll = roll; t.held = m_held;
      t.dsec = m_held ? m_lsec : m_sec;
      t.dmin = m_held ? m_lmin : m_min;
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
    enable = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: sec_tick is the output-valid for the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rollover && !sec_tick) chk("rollover_without_tick", 1, 0);
      if (sec_tick) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          tick_t e;
          e = exp_q.pop_front();
          chk("tick_seconds", int'(seconds), e.sec);
          chk("tick_minutes", int'(minutes), e.min);
          chk("tick_rollover", int'(rollover), e.roll);
          chk("tick_disp_sec", int'(disp_sec), e.dsec);
          chk("tick_disp_min", int'(disp_min), e.dmin);
          chk("tick_lap_held", int'(lap_held), e.held);
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_seconds"}, int'(seconds), 0);
    chk({name, "_minutes"}, int'(minutes), 0);
    chk({name, "_disp_sec"}, int'(disp_sec), 0);
    chk({name, "_disp_min"}, int'(disp_min), 0);
    chk({name, "_sec_tick"}, int'(sec_tick), 0);
    chk({name, "_rollover"}, int'(rollover), 0);
    chk({name, "_lap_held"}, int'(lap_held), 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous count: first tick on the 4th enabled edge
    run(3);
    chk("pre_tick_seconds", int'(seconds), 0);
    chk("pre_tick_sec_tick", int'(sec_tick), 0);
    run(1);
    chk("first_tick", int'(sec_tick), 1);
    chk("first_seconds", int'(seconds), 1);
    chk("first_minutes", int'(minutes), 0);
    run(1);
    chk("tick_one_cycle", int'(sec_tick), 0);

    // Pause and resume: prescaler keeps its fraction (now 1, then 3, then wraps)
    run(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    chk("pause_seconds", int'(seconds), 1);
    chk("pause_no_tick", int'(sec_tick), 0);
    run(1);
    chk("resume_seconds", int'(seconds), 2);
    chk("resume_tick", int'(sec_tick), 1);

    // Minute carry
    step(1'b0, 1'b1, 1'b0);
    chk_zero("clear1");
    run(239);
    chk("carry_prev_sec", int'(seconds), 59);
    run(1);
    chk("carry_minutes", int'(minutes), 1);
    chk("carry_seconds", int'(seconds), 0);
    chk("carry_rollover", int'(rollover), 0);

    // Full wrap from 99:59 to 00:00
    step(1'b0, 1'b1, 1'b0);
    run(23999);
    chk("wrap_prev_min", int'(minutes), 99);
    chk("wrap_prev_sec", int'(seconds), 59);
    run(1);
    chk("wrap_minutes", int'(minutes), 0);
    chk("wrap_seconds", int'(seconds), 0);
    chk("wrap_tick", int'(sec_tick), 1);
    chk("wrap_rollover", int'(rollover), 1);

    // Clear priority at terminal count with 05:59
    step(1'b0, 1'b1, 1'b0);
    run(1439);
    chk("prio_prev_min", int'(minutes), 5);
    chk("prio_prev_sec", int'(seconds), 59);
    step(1'b1, 1'b1, 1'b1);
    chk_zero("clear_prio");

    // Asynchronous reset mid-count (01 s, prescaler=2)
    run(6);
    chk("pre_rst_seconds", int'(seconds), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run(3);
    chk("rst_full_period", int'(seconds), 0);
    run(1);
    chk("rst_restart_sec", int'(seconds), 1);

`ifdef STOPWATCH_LAP_EN
    step(1'b0, 1'b1, 1'b0);
    run(12);
    chk("lap_pre_sec", int'(seconds), 3);
    step(1'b1, 1'b0, 1'b1);
    chk("lap_held_set", int'(lap_held), 1);
    run(8);
    chk("lap_disp_frozen", int'(disp_sec), 3);
    chk("lap_live_sec", int'(seconds), 5);
    chk("lap_held_on", int'(lap_held), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("lap_release_held", int'(lap_held), 0);
    chk("lap_release_disp", int'(disp_sec), 5);
    step(1'b0, 1'b0, 1'b1);
    chk("lap_again_held", int'(lap_held), 1);
    step(1'b0, 1'b1, 1'b0);
    chk_zero("lap_clear");
`else
    run(2);
    step(1'b1, 1'b0, 1'b1);
    chk("lap_ignored_held", int'(lap_held), 0);
    chk("lap_ignored_disp", int'(disp_sec), 1);
    run(1);
    chk("lap_ignored_tick_disp", int'(disp_sec), 2);
`endif

    run(1);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
- Downstream timekeeping stage driven by the stopwatch control FSM.
- Consumes the FSM's `enable` level, plus a synchronous clear pulse issued when the FSM returns to IDLE.
- Divides `clk` down to a 1 s tick and keeps an MM:SS elapsed-time count.
- Feeds the display path, with an optional lap-freeze display register.

Parameters:
- CLK_DIV, 50_000_000: clk cycles per second tick. Must be ≥2. Use 4 in simulation.
- MAX_MIN, 99: highest minute value before the count wraps to 00:00. Must be ≤127.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- enable  input  1  count-enable level from the control FSM (high only in RUNNING).
- clear  input  1  synchronous clear; pulse from the FSM reset path.
- lap  input  1  lap button pulse; used only when STOPWATCH_LAP_EN is defined.
- seconds  output  6  live seconds, 0..59.
- minutes  output  7  live minutes, 0..MAX_MIN.
- disp_sec  output  6  seconds for the display.
- disp_min  output  7  minutes for the display.
- sec_tick  output  1  one-cycle pulse, coincident with each seconds update.
- rollover  output  1  one-cycle pulse when MM:SS wraps from MAX_MIN:59 to 00:00.
- lap_held  output  1  high while the display is frozen (lap mode).

Behaviour:
- Reset values: while `rst` is high, every register and output is 0 (prescaler, seconds, minutes, disp_*, sec_tick, rollover, lap_held). Reset takes effect asynchronously and is released synchronously with `clk`.
- Prescaler:
  - Width is $clog2(CLK_DIV).
  - When `enable`=1 and `clear`=0, it increments each cycle.
  - At CLK_DIV-1 it wraps to 0, and that same edge advances the time count.
  - When `enable`=0 it holds its value, so a pause preserves the fractional second.
- Time count:
  - On the wrapping edge, seconds increments.
  - At seconds=59, seconds goes to 0 and minutes increments.
  - At minutes=MAX_MIN and seconds=59, both go to 0.
- Output pulses (registered):
  - `sec_tick` is 1 for exactly one cycle, in the same cycle the new seconds value is visible.
  - `rollover` is 1 in the same cycle as the `sec_tick` of the wrap to 00:00.
- Latency: the first `sec_tick` comes CLK_DIV enabled cycles after clear/reset, i.e. the output changes after the CLK_DIV-th enabled rising edge.
- Clear:
  - Synchronous. Zeros the prescaler, seconds, minutes, display registers and lap_held.
  - Suppresses `sec_tick` and `rollover` for that edge.
  - Has priority over `enable` and `lap`, including when it coincides with a terminal count.
- Enable and clear both low: all state holds and the pulses are 0.
- Reset mid-count: state is lost and counting restarts from 00:00 with a full CLK_DIV period.
- No internal FSM state is visible to the control FSM. Status is owned upstream.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- When defined:
  - A `lap` pulse while `lap_held`=0 copies the live seconds/minutes into disp_sec/disp_min on that edge and sets `lap_held`=1.
  - While held, disp_* stays frozen and the live count keeps running.
  - A `lap` pulse while `lap_held`=1 clears `lap_held`. disp_* tracks live values from the next cycle.
  - `lap` is honoured regardless of `enable`. `clear` and `rst` override it.
  - While not held, disp_* is registered live count (equal to seconds/minutes, delayed 0 cycles via a mux on the held flag).
- When not defined:
  - disp_sec=seconds and disp_min=minutes combinationally.
  - `lap` is ignored and `lap_held` is tied to 0.
  - No display registers are inferred.

Test Plan (CLK_DIV=4, MAX_MIN=99):
- Reset then continuous count: assert rst, release, hold enable=1 for 4 cycles -> seconds=1, minutes=0, sec_tick high for exactly 1 cycle on the 4th edge.
- Pause and resume: enable=1 for 2 cycles, enable=0 for 10 cycles, enable=1 for 2 cycles -> seconds goes 0→1 on the 4th enabled edge, with no tick during the pause.
- Minute carry: 240 enabled cycles from 00:00 -> minutes=1, seconds=0; the tick at cycle 240 has rollover=0.
- Full wrap: 24000 enabled cycles -> 00:00, sec_tick=1 and rollover=1 on the same cycle. The previous value was 99:59.
- Clear priority: clear=1 on the edge where the prescaler=3 and seconds=59, minutes=5 -> all zero, sec_tick=0, rollover=0. Also, rst pulsed mid-count (prescaler=2) -> all outputs 0 immediately, asynchronously.
- Lap (STOPWATCH_LAP_EN):
  - Lap at 00:03, then 8 more enabled cycles -> disp_sec=3, seconds=5, lap_held=1.
  - Second lap -> disp_sec=5 next cycle, lap_held=0.
  - Clear during hold -> lap_held=0 and disp_*=0.
